// File: rtl/axis_gvp_vector_ramp.sv
// axis_gvp_vector_ramp
// Generalized vector probe (GVP) program executor. Walks a 16-entry vector
// table, adding per-step increments to four saturating Q31 accumulators
// (Xs, Ys, Zs, U) at a programmed decimation, and strobes gvp_sample on
// every applied step.
//
// Optional build macro: GVP_VECTOR_LOOPS_EN
//   defined   -> each entry may jump back to entry 'next' up to 'loops' times
//   undefined -> the table runs strictly sequentially
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a rising edge of run; accumulators hold position
// LOAD   | copy table[index] into working registers, end marker -> IDLE
// RUN    | count decimation, apply one step per decii+1 clocks
// HOLD   | frozen mid-vector, resumes RUN with no step lost
// NEXT   | pick the following entry (sequential or loop jump)

module axis_gvp_vector_ramp #(
  parameter int          SAXIS_TDATA_WIDTH   = 32,
  parameter int          NVEC_BITS           = 4,
  parameter logic [31:0] vector_reg_address  = 32'd1200,
  parameter logic [31:0] control_reg_address = 32'd1201
) (
  input  logic                         a_clk,
  input  logic                         a_rst,
  input  logic [31:0]                  config_addr,
  input  logic [511:0]                 config_data,
  output logic [SAXIS_TDATA_WIDTH-1:0] M_AXIS_Xs_tdata,
  output logic                         M_AXIS_Xs_tvalid,
  output logic [SAXIS_TDATA_WIDTH-1:0] M_AXIS_Ys_tdata,
  output logic                         M_AXIS_Ys_tvalid,
  output logic [SAXIS_TDATA_WIDTH-1:0] M_AXIS_Zs_tdata,
  output logic                         M_AXIS_Zs_tvalid,
  output logic [SAXIS_TDATA_WIDTH-1:0] M_AXIS_U_tdata,
  output logic                         M_AXIS_U_tvalid,
  output logic                         gvp_sample,
  output logic                         gvp_busy,
  output logic [NVEC_BITS-1:0]         gvp_index
);

  localparam int NVEC = 1 << NVEC_BITS;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
  localparam logic [2:0] S_NEXT = 3'd4;

  // Symmetric Q31 saturation limits: the most negative code is never produced.
  localparam logic signed [32:0] SAT_POS = 33'sh0_7fff_ffff;
  localparam logic signed [32:0] SAT_NEG = -33'sh0_7fff_ffff;

  // Vector table (not reset; contents survive a reset)
  logic [31:0] tab_nsteps [NVEC];
  logic [15:0] tab_decii  [NVEC];
  logic [31:0] tab_dx     [NVEC];
  logic [31:0] tab_dy     [NVEC];
  logic [31:0] tab_dz     [NVEC];
  logic [31:0] tab_du     [NVEC];
`ifdef GVP_VECTOR_LOOPS_EN
  logic [NVEC_BITS-1:0] tab_next  [NVEC];
  logic [15:0]          tab_loops [NVEC];
  logic [NVEC_BITS-1:0] cur_next;
  logic [15:0]          cur_loops;
  logic [15:0]          loop_cnt [NVEC];
`endif

  // Control registers and run edge detector
  logic run_r;
  logic hold_r;
  logic run_q;
  logic run_rise;

  // Working copy of the active entry
  logic [31:0] cur_nsteps;
  logic [15:0] cur_decii;
  logic [31:0] cur_dx;
  logic [31:0] cur_dy;
  logic [31:0] cur_dz;
  logic [31:0] cur_du;

  logic [2:0]           state;
  logic [NVEC_BITS-1:0] idx;
  logic [31:0]          step_cnt;
  logic [15:0]          dec_cnt;
  logic [31:0]          step_cnt_inc;
  logic [31:0]          acc_x;
  logic [31:0]          acc_y;
  logic [31:0]          acc_z;
  logic [31:0]          acc_u;
  logic                 sample_r;

  logic [NVEC_BITS-1:0] wr_idx;
  logic                 vec_wr;
  logic                 ctl_wr;

  logic unused_cfg;

  assign wr_idx       = config_data[NVEC_BITS-1:0];
  assign vec_wr       = (config_addr == vector_reg_address);
  assign ctl_wr       = (config_addr == control_reg_address);
  assign run_rise     = run_r & ~run_q;
  assign step_cnt_inc = step_cnt + 32'd1;

`ifdef GVP_VECTOR_LOOPS_EN
  assign unused_cfg = ^{config_data[511:256], config_data[239:228],
                        config_data[95:80], config_data[31:NVEC_BITS]};
`else
  assign unused_cfg = ^{config_data[511:224], config_data[95:80],
                        config_data[31:NVEC_BITS]};
`endif

  // 33-bit add of two Q31 values clamped to +/-(2^31-1)
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic signed [32:0] s;
    s = $signed({a[31], a}) + $signed({b[31], b});
    if (s > SAT_POS)
      sat_add = 32'h7fff_ffff;
    else if (s < SAT_NEG)
      sat_add = 32'h8000_0001;
    else
      sat_add = s[31:0];
  endfunction

  // Latch run/hold from the config bus; they keep their value between writes
  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      run_r  <= 1'b0;
      hold_r <= 1'b0;
    end else if (ctl_wr) begin
      run_r  <= config_data[0];
      hold_r <= config_data[1];
    end
  end

  // Table write port; a write to the active entry only matters at its next LOAD
  always_ff @(posedge a_clk) begin
    if (vec_wr) begin
      tab_nsteps[wr_idx] <= config_data[63:32];
      tab_decii[wr_idx]  <= config_data[79:64];
      tab_dx[wr_idx]     <= config_data[127:96];
      tab_dy[wr_idx]     <= config_data[159:128];
      tab_dz[wr_idx]     <= config_data[191:160];
      tab_du[wr_idx]     <= config_data[223:192];
`ifdef GVP_VECTOR_LOOPS_EN
      tab_next[wr_idx]   <= config_data[224 +: NVEC_BITS];
      tab_loops[wr_idx]  <= config_data[255:240];
`endif
    end
  end

  // Program sequencer, decimation/step counters and saturating accumulators
  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      step_cnt   <= '0;
      dec_cnt    <= '0;
      acc_x      <= '0;
      acc_y      <= '0;
      acc_z      <= '0;
      acc_u      <= '0;
      sample_r   <= 1'b0;
      run_q      <= 1'b0;
      cur_nsteps <= '0;
      cur_decii  <= '0;
      cur_dx     <= '0;
      cur_dy     <= '0;
      cur_dz     <= '0;
      cur_du     <= '0;
`ifdef GVP_VECTOR_LOOPS_EN
      cur_next   <= '0;
      cur_loops  <= '0;
      for (int i = 0; i < NVEC; i++) loop_cnt[i] <= '0;
`endif
    end else begin
      sample_r <= 1'b0;
      run_q    <= run_r;
      case (state)
        S_IDLE: begin
          if (run_rise) begin
            state <= S_LOAD;
            idx   <= '0;
`ifdef GVP_VECTOR_LOOPS_EN
            for (int i = 0; i < NVEC; i++) loop_cnt[i] <= '0;
`endif
          end
        end

        S_LOAD: begin
          if (!run_r) begin
            state <= S_IDLE;
          end else begin
            cur_nsteps <= tab_nsteps[idx];
            cur_decii  <= tab_decii[idx];
            cur_dx     <= tab_dx[idx];
            cur_dy     <= tab_dy[idx];
            cur_dz     <= tab_dz[idx];
            cur_du     <= tab_du[idx];
`ifdef GVP_VECTOR_LOOPS_EN
            cur_next   <= tab_next[idx];
            cur_loops  <= tab_loops[idx];
`endif
            step_cnt   <= '0;
            dec_cnt    <= '0;
            state      <= (tab_nsteps[idx] == 32'd0) ? S_IDLE : S_RUN;
          end
        end

        S_RUN: begin
          // Abort beats hold; hold is taken before any step in this cycle
          if (!run_r) begin
            state <= S_IDLE;
          end else if (hold_r) begin
            state <= S_HOLD;
          end else if (dec_cnt == cur_decii) begin
            dec_cnt  <= '0;
            acc_x    <= sat_add(acc_x, cur_dx);
            acc_y    <= sat_add(acc_y, cur_dy);
            acc_z    <= sat_add(acc_z, cur_dz);
            acc_u    <= sat_add(acc_u, cur_du);
            sample_r <= 1'b1;
            step_cnt <= step_cnt_inc;
            if (step_cnt_inc == cur_nsteps) state <= S_NEXT;
          end else begin
            dec_cnt <= dec_cnt + 16'd1;
          end
        end

        S_HOLD: begin
          if (!run_r)
            state <= S_IDLE;
          else if (!hold_r)
            state <= S_RUN;
        end

        S_NEXT: begin
          if (!run_r) begin
            state <= S_IDLE;
          end else begin
`ifdef GVP_VECTOR_LOOPS_EN
            if ((cur_loops != 16'd0) && (loop_cnt[idx] < cur_loops)) begin
              loop_cnt[idx] <= loop_cnt[idx] + 16'd1;
              idx           <= cur_next;
              state         <= S_LOAD;
            end else begin
              loop_cnt[idx] <= '0;
              if (idx == '1) begin
                state <= S_IDLE;
              end else begin
                idx   <= idx + 1'b1;
                state <= S_LOAD;
              end
            end
`else
            if (idx == '1) begin
              state <= S_IDLE;
            end else begin
              idx   <= idx + 1'b1;
              state <= S_LOAD;
            end
`endif
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign M_AXIS_Xs_tdata  = acc_x;
  assign M_AXIS_Ys_tdata  = acc_y;
  assign M_AXIS_Zs_tdata  = acc_z;
  assign M_AXIS_U_tdata   = acc_u;
  assign M_AXIS_Xs_tvalid = 1'b1;
  assign M_AXIS_Ys_tvalid = 1'b1;
  assign M_AXIS_Zs_tvalid = 1'b1;
  assign M_AXIS_U_tvalid  = 1'b1;
  assign gvp_sample       = sample_r;
  assign gvp_busy         = (state != S_IDLE);
  assign gvp_index        = idx;

endmodule

// File: tb/tb_axis_gvp_vector_ramp.sv
// Bench for axis_gvp_vector_ramp: directed and random vector programs,
// expected step outputs queued by a table-walking reference model and
// checked by a monitor on every gvp_sample pulse.

module tb_axis_gvp_vector_ramp;

  logic         a_clk;
  logic         a_rst;
  logic [31:0]  config_addr;
  logic [511:0] config_data;
  logic [31:0]  xs, ys, zs, us;
  logic         xs_v, ys_v, zs_v, us_v;
  logic         gvp_sample, gvp_busy;
  logic [3:0]   gvp_index;

  axis_gvp_vector_ramp dut (
    .a_clk            (a_clk),
    .a_rst            (a_rst),
    .config_addr      (config_addr),
    .config_data      (config_data),
    .M_AXIS_Xs_tdata  (xs),
    .M_AXIS_Xs_tvalid (xs_v),
    .M_AXIS_Ys_tdata  (ys),
    .M_AXIS_Ys_tvalid (ys_v),
    .M_AXIS_Zs_tdata  (zs),
    .M_AXIS_Zs_tvalid (zs_v),
    .M_AXIS_U_tdata   (us),
    .M_AXIS_U_tvalid  (us_v),
    .gvp_sample       (gvp_sample),
    .gvp_busy         (gvp_busy),
    .gvp_index        (gvp_index)
  );

  initial a_clk = 1'b0;
  always #5 a_clk = ~a_clk;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    logic [31:0] u;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;
  int samples = 0;
  logic [31:0] lx = 0, ly = 0, lz = 0, lu = 0;

  // reference model: table contents and accumulator position
  int unsigned m_ns  [16];
  int unsigned m_dec [16];
  int          m_dx  [16];
  int          m_dy  [16];
  int          m_dz  [16];
  int          m_du  [16];
  int          m_nxt [16];
  int          m_lp  [16];
  longint      mx = 0, my = 0, mz = 0, mu = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end
  endtask

  function automatic longint sat(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483647) return -64'sd2147483647;
    return v;
  endfunction

  // Monitor: every sample pulse must match the next queued expectation
  always @(negedge a_clk) begin
    if (!a_rst && gvp_sample) begin
      samples++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL step unexpected sample got=%h want=none", xs);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("step_x", xs, e.x);
        check("step_y", ys, e.y);
        check("step_z", zs, e.z);
        check("step_u", us, e.u);
        lx = e.x; ly = e.y; lz = e.z; lu = e.u;
      end
    end
  end

  task automatic cfg_write(input logic [31:0] addr, input logic [511:0] data);
    @(posedge a_clk); #1;
    config_addr = addr;
    config_data = data;
    @(posedge a_clk); #1;
    config_addr = '0;
    config_data = '0;
  endtask

  task automatic write_vec(input int idx, input int unsigned ns, input int unsigned dec,
                           input int dx, input int dy, input int dz, input int du,
                           input int nxt, input int lp);
    logic [511:0] d;
    d = '0;
    d[3:0]     = idx[3:0];
    d[63:32]   = ns;
    d[95:64]   = dec;
    d[127:96]  = dx;
    d[159:128] = dy;
    d[191:160] = dz;
    d[223:192] = du;
    d[227:224] = nxt[3:0];
    d[255:240] = lp[15:0];
    m_ns[idx] = ns; m_dec[idx] = dec & 32'hffff;
    m_dx[idx] = dx; m_dy[idx] = dy; m_dz[idx] = dz; m_du[idx] = du;
    m_nxt[idx] = nxt; m_lp[idx] = lp;
    cfg_write(32'd1200, d);
  endtask

  task automatic set_ctrl(input bit run, input bit hold);
    logic [511:0] d;
    d = '0;
    d[0] = run;
    d[1] = hold;
    cfg_write(32'd1201, d);
  endtask

  // Walk the program as a list of entries and push every expected step
  task automatic model_walk();
    int idx = 0;
    int lc[16];
    exp_t e;
    foreach (lc[i]) lc[i] = 0;
    for (int guard = 0; guard < 2000; guard++) begin
      if (m_ns[idx] == 0) break;
      for (int s = 0; s < int'(m_ns[idx]); s++) begin
        mx = sat(mx + m_dx[idx]);
        my = sat(my + m_dy[idx]);
        mz = sat(mz + m_dz[idx]);
        mu = sat(mu + m_du[idx]);
        e.x = mx[31:0]; e.y = my[31:0]; e.z = mz[31:0]; e.u = mu[31:0];
        exp_q.push_back(e);
      end
`ifdef GVP_VECTOR_LOOPS_EN
      if (m_lp[idx] > 0 && lc[idx] < m_lp[idx]) begin
        lc[idx]++;
        idx = m_nxt[idx];
        continue;
      end
      lc[idx] = 0;
`endif
      if (idx == 15) break;
      idx++;
    end
  endtask

  // Queue expectations, raise run, and check first-step latency
  task automatic start_program();
    int n;
    model_walk();
    set_ctrl(1'b0, 1'b0);
    set_ctrl(1'b1, 1'b0);
    if (m_ns[0] != 0) begin
      n = 0;
      @(negedge a_clk);
      while (!gvp_sample && n < 200) begin
        @(negedge a_clk);
        n++;
      end
      check("latency", n, 3 + m_dec[0]);
    end else begin
      repeat (4) @(negedge a_clk);
    end
  endtask

  task automatic finish_program(input string name);
    int n = 0;
    while (gvp_busy && n < 20000) begin
      @(negedge a_clk);
      n++;
    end
    if (gvp_busy) begin
      total++;
      bad++;
      $display("FAIL %s timeout got=busy want=idle", name);
    end
    repeat (2) @(negedge a_clk);
    check({name, "_pending"}, exp_q.size(), 0);
    check({name, "_x"}, xs, mx[31:0]);
    check({name, "_y"}, ys, my[31:0]);
    check({name, "_z"}, zs, mz[31:0]);
    check({name, "_u"}, us, mu[31:0]);
  endtask

  initial begin
    int s0;
    a_rst = 1'b1;
    config_addr = '0;
    config_data = '0;
    repeat (3) @(posedge a_clk);
    #1 a_rst = 1'b0;
    @(negedge a_clk);
    check("rst_x", xs, 0);
    check("rst_y", ys, 0);
    check("rst_z", zs, 0);
    check("rst_u", us, 0);
    check("rst_valid", {xs_v, ys_v, zs_v, us_v}, 4'hf);
    check("rst_busy", gvp_busy, 0);
    check("rst_sample", gvp_sample, 0);
    check("rst_index", gvp_index, 0);

    // basic ramp, decii=0: four back-to-back steps
    write_vec(0, 4, 0, 100, 0, 0, 0, 0, 0);
    write_vec(1, 0, 0, 0, 0, 0, 0, 0, 0);
    start_program();
    check("ramp_index", gvp_index, 0);
    check("ramp_busy", gvp_busy, 1);
    for (int i = 1; i < 4; i++) begin
      @(negedge a_clk);
      check("ramp_consec", gvp_sample, 1);
    end
    @(negedge a_clk);
    check("ramp_gap", gvp_sample, 0);
    finish_program("ramp");
    check("ramp_final", xs, 32'd400);

`ifdef GVP_VECTOR_LOOPS_EN
    write_vec(0, 1, 0, 1, 0, 0, 0, 0, 2);
    write_vec(1, 0, 0, 0, 0, 0, 0, 0, 0);
    start_program();
    finish_program("loop");
    check("loop_final", xs, 32'd403);
    write_vec(0, 1, 0, 0, 0, 0, 0, 0, 0);
`endif

    // decimated bias ramp with a hold in the middle
    write_vec(0, 2, 3, 0, 0, 0, -5, 0, 0);
    write_vec(1, 0, 0, 0, 0, 0, 0, 0, 0);
    s0 = samples;
    start_program();
    set_ctrl(1'b1, 1'b1);
    repeat (2) @(negedge a_clk);
    begin
      int sh;
      sh = samples;
      repeat (10) @(negedge a_clk);
      check("hold_nosample", samples, sh);
    end
    check("hold_u", us, 32'hffff_fffb);
    check("hold_busy", gvp_busy, 1);
    set_ctrl(1'b1, 1'b0);
    finish_program("hold");
    check("hold_final_u", us, 32'hffff_fff6);
    check("hold_steps", samples - s0, 2);

    // saturation in both directions
    write_vec(0, 1, 0, 32'h7fff_0000, -32'sh7fff_0000, 0, 0, 0, 0);
    write_vec(1, 3, 0, 32'h4000_0000, -32'sh4000_0000, 0, 0, 0, 0);
    write_vec(2, 0, 0, 0, 0, 0, 0, 0, 0);
    start_program();
    finish_program("sat");
    check("sat_pos", xs, 32'h7fff_ffff);
    check("sat_neg", ys, 32'h8000_0001);

    // abort mid-run
    write_vec(0, 10, 1, -1000, 0, 0, 1, 0, 0);
    write_vec(1, 0, 0, 0, 0, 0, 0, 0, 0);
    start_program();
    set_ctrl(1'b0, 1'b0);
    repeat (2) @(negedge a_clk);
    s0 = samples;
    repeat (20) @(negedge a_clk);
    check("abort_nosample", samples, s0);
    check("abort_busy", gvp_busy, 0);
    check("abort_cut", exp_q.size() > 0, 1);
    check("abort_x", xs, lx);
    check("abort_u", us, lu);
    exp_q.delete();
    mx = longint'($signed(lx)); my = longint'($signed(ly));
    mz = longint'($signed(lz)); mu = longint'($signed(lu));

    // full table, no end marker: stops after entry 15
    for (int i = 0; i < 16; i++) write_vec(i, 1, 0, 0, 0, 3, 0, 0, 0);
    start_program();
    finish_program("full");
    check("full_z", zs, 32'd48);

    // random programs
    for (int p = 0; p < 4; p++) begin
      int n;
      n = $urandom_range(4, 1);
      for (int i = 0; i < n; i++)
        write_vec(i, $urandom_range(3, 1), $urandom_range(2, 0),
                  int'($urandom), int'($urandom), int'($urandom) >>> 4, int'($urandom) >>> 8,
                  $urandom_range(i, 0), $urandom_range(1, 0));
      write_vec(n, 0, 0, 0, 0, 0, 0, 0, 0);
      start_program();
      finish_program("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
